// File: rtl/pipeline_if_id_if.sv
// Signal bundle between fetch, EX-stage feedback and the IF/ID pipeline register.
// master drives fetch/EX inputs; slave is the IF/ID register itself.
interface pipeline_if_id_if;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] PC;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        EX_BranchTaken;
  logic [2:0]  ID_PCSrc;
  logic        IRQ;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC;
  logic        ID_Valid;
  logic        stall;
  logic        ID_Flush;
  logic        IRQ_Take;
  logic [31:0] EPC;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output IF_Instruction, IF_PC, PC, EX_MemRead, EX_Rt, EX_BranchTaken, ID_PCSrc, IRQ,
    input  ID_Instruction, ID_PC, ID_Valid, stall, ID_Flush, IRQ_Take, EPC, stall_cnt, flush_cnt
  );

  modport slave (
    input  IF_Instruction, IF_PC, PC, EX_MemRead, EX_Rt, EX_BranchTaken, ID_PCSrc, IRQ,
    output ID_Instruction, ID_PC, ID_Valid, stall, ID_Flush, IRQ_Take, EPC, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_if_id.sv
// IF/ID pipeline register with load-use stall, branch/jump squash and interrupt take.
// Optional performance counters are enabled with the IFID_PERF_EN macro.
module pipeline_if_id #(
  parameter logic [31:0] NOP        = 32'h00000000,
  parameter logic [31:0] RESET_IDPC = 32'h80000004
) (
  input logic             clk,
  input logic             reset,
  pipeline_if_id_if.slave bus
);

  typedef enum logic [1:0] {RUN, DEFER, HANDLER} state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] epc_reg, epc_next;
  logic        valid_reg, valid_next;

  logic [1:0]  src_match;
  logic        hz;
  logic        irq_ok;
  logic        take;
  logic        is_jump;
  logic        stall_c;
  logic        flush_c;
  logic        take_c;
  logic        flush_event;

  // Compare the load destination against rs (gi=0, bits 25:21) and rt (gi=1, bits 20:16).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
      assign src_match[gi] = (bus.EX_Rt == instr_reg[21 - 5*gi +: 5]);
    end
  endgenerate

  assign hz      = valid_reg & bus.EX_MemRead & (bus.EX_Rt != 5'd0) & (|src_match);
  assign irq_ok  = bus.IRQ & ~bus.PC[31] & (state_reg == RUN);
  assign take    = irq_ok | (state_reg == DEFER);
  assign is_jump = valid_reg & ((bus.ID_PCSrc == 3'd2) | (bus.ID_PCSrc == 3'd3));

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    pc_next     = pc_reg;
    epc_next    = epc_reg;
    valid_next  = valid_reg;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    take_c      = 1'b0;
    flush_event = 1'b0;

    if (bus.EX_BranchTaken) begin
      // An interrupt arriving with a taken branch waits one cycle so EPC
      // picks up the branch target from PC.
      instr_next  = NOP;
      valid_next  = 1'b0;
      flush_c     = 1'b1;
      flush_event = 1'b1;
      if (irq_ok) begin
        state_next = DEFER;
      end
    end else if (take) begin
      take_c      = 1'b1;
      flush_c     = 1'b1;
      flush_event = 1'b1;
      instr_next  = NOP;
      valid_next  = 1'b0;
      epc_next    = valid_reg ? (pc_reg - 32'd4) : bus.PC;
      state_next  = HANDLER;
    end else if (hz) begin
      stall_c = 1'b1;
      flush_c = 1'b1;
    end else if (is_jump) begin
      instr_next  = NOP;
      valid_next  = 1'b0;
      flush_event = 1'b1;
    end else begin
      instr_next = bus.IF_Instruction;
      pc_next    = bus.IF_PC;
      valid_next = 1'b1;
    end

    if ((state_reg == HANDLER) && !bus.PC[31]) begin
      state_next = RUN;
    end

    if (reset) begin
      stall_c     = 1'b0;
      flush_c     = 1'b0;
      take_c      = 1'b0;
      flush_event = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      instr_reg <= NOP;
      pc_reg    <= RESET_IDPC;
      epc_reg   <= 32'h00000000;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      instr_reg <= instr_next;
      pc_reg    <= pc_next;
      epc_reg   <= epc_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.ID_Instruction = instr_reg;
  assign bus.ID_PC          = pc_reg;
  assign bus.ID_Valid       = valid_reg;
  assign bus.EPC            = epc_reg;
  assign bus.stall          = stall_c;
  assign bus.ID_Flush       = flush_c;
  assign bus.IRQ_Take       = take_c;

`ifdef IFID_PERF_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 16'h0000;
      flush_cnt_reg <= 16'h0000;
    end else begin
      if (stall_c && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (flush_event && (flush_cnt_reg != 16'hFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif

endmodule
